// File: rtl/buzz_pattern_driver.sv
// buzz_pattern_driver: turns the b1/b2 alarm request levels into a square-wave piezo drive.
//   b1 -> fixed burst of BEEPS beeps (ON_CYC on, OFF_CYC silent), tone half-period TONE_DIV.
//   b2 -> continuous tone, half-period TONE_DIV/2, pre-empts any b1 burst.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   b1, b2     alarm request levels (registered once before use)
//   mute       (only with BUZZ_MUTE_EN) forces tone low without disturbing timing
//   tone       square-wave drive to the buzzer pin
//   busy       high whenever the FSM is not idle
//   mode       current state: 0 idle, 1 beep-on, 2 beep-off, 3 continuous
//   burst_done one-cycle pulse when a b1 burst completes
// Optional feature macro: BUZZ_MUTE_EN (adds the mute input).
module buzz_pattern_driver #(
  parameter int unsigned TONE_DIV = 4,
  parameter int unsigned ON_CYC   = 16,
  parameter int unsigned OFF_CYC  = 8,
  parameter int unsigned BEEPS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
`ifdef BUZZ_MUTE_EN
  input  logic       mute,
`endif
  output logic       tone,
  output logic       busy,
  output logic [1:0] mode,
  output logic       burst_done
);

  localparam int unsigned PhaseMax = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;
  localparam int unsigned BeepW    = (BEEPS > 1) ? $clog2(BEEPS) : 1;
  localparam int unsigned DivW     = $clog2(TONE_DIV);

  localparam logic [PhaseW-1:0] OnLast   = PhaseW'(ON_CYC - 1);
  localparam logic [PhaseW-1:0] OffLast  = PhaseW'(OFF_CYC - 1);
  localparam logic [BeepW-1:0]  BeepLast = BeepW'(BEEPS - 1);
  localparam logic [DivW-1:0]   DivLast  = DivW'(TONE_DIV - 1);
  localparam logic [DivW-1:0]   HalfLast = DivW'(TONE_DIV / 2 - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBeepOn  = 2'd1,
    StBeepOff = 2'd2,
    StCont    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              b1_q, b2_q;
  logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
  logic [BeepW-1:0]  beep_cnt_q, beep_cnt_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic              tone_q, tone_d;
  logic              burst_done_q, burst_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      b1_q         <= 1'b0;
      b2_q         <= 1'b0;
      phase_cnt_q  <= '0;
      beep_cnt_q   <= '0;
      div_cnt_q    <= '0;
      tone_q       <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      b1_q         <= b1;
      b2_q         <= b2;
      phase_cnt_q  <= phase_cnt_d;
      beep_cnt_q   <= beep_cnt_d;
      div_cnt_q    <= div_cnt_d;
      tone_q       <= tone_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Sequencing FSM: only the registered request copies are used.
  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    beep_cnt_d   = beep_cnt_q;
    burst_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        phase_cnt_d = '0;
        beep_cnt_d  = '0;
        if (b2_q) begin
          state_d = StCont;
        end else if (b1_q) begin
          state_d = StBeepOn;
        end
      end
      StBeepOn: begin
        if (b2_q) begin
          state_d     = StCont;
          phase_cnt_d = '0;
          beep_cnt_d  = '0;
        end else if (phase_cnt_q == OnLast) begin
          state_d     = StBeepOff;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      StBeepOff: begin
        if (b2_q) begin
          state_d     = StCont;
          phase_cnt_d = '0;
          beep_cnt_d  = '0;
        end else if (phase_cnt_q == OffLast) begin
          phase_cnt_d = '0;
          if (beep_cnt_q == BeepLast) begin
            state_d      = StIdle;
            beep_cnt_d   = '0;
            burst_done_d = 1'b1;
          end else begin
            state_d    = StBeepOn;
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      StCont: begin
        phase_cnt_d = '0;
        beep_cnt_d  = '0;
        if (!b2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tone generator: restarts low on every entry to a sounding state, silent otherwise.
  always_comb begin
    tone_d    = 1'b0;
    div_cnt_d = '0;
    if ((state_d == StBeepOn || state_d == StCont) && state_d == state_q) begin
      if (div_cnt_q == ((state_q == StCont) ? HalfLast : DivLast)) begin
        tone_d    = ~tone_q;
        div_cnt_d = '0;
      end else begin
        tone_d    = tone_q;
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

`ifdef BUZZ_MUTE_EN
  assign tone = tone_q & ~mute;
`else
  assign tone = tone_q;
`endif
  assign busy       = (state_q != StIdle);
  assign mode       = state_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_buzz_pattern_driver.sv
// Directed bench for buzz_pattern_driver with default parameters.
module tb_buzz_pattern_driver;

  logic       clk = 1'b0;
  logic       rst, b1, b2;
`ifdef BUZZ_MUTE_EN
  logic       mute;
`endif
  logic       tone, busy, burst_done;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;

  buzz_pattern_driver dut (
    .clk        (clk),
    .rst        (rst),
    .b1         (b1),
    .b2         (b2),
`ifdef BUZZ_MUTE_EN
    .mute       (mute),
`endif
    .tone       (tone),
    .busy       (busy),
    .mode       (mode),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " mode"}, int'(mode), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " tone"}, int'(tone), 0);
    chk({tag, " done"}, int'(burst_done), 0);
  endtask

  int r, exp_mode, exp_tone, cnt_a, cnt_b, first_done, second_done;

  initial begin
    rst = 1'b1; b1 = 1'b1; b2 = 1'b1;
`ifdef BUZZ_MUTE_EN
    mute = 1'b0;
`endif
    // 1. Reset held with both requests high.
    tick();
    chk_idle("rst1");
    tick();
    chk_idle("rst2");
    rst = 1'b0;
    tick();
    chk("post_rst_lat1 mode", int'(mode), 0);
    tick();
    chk("post_rst_lat2 mode", int'(mode), 3);
    b1 = 1'b0; b2 = 1'b0;
    tick(2);
    chk_idle("post_rst_release");

    // 2. Single-cycle b1 pulse -> one full burst.
    b1 = 1'b1;
    tick();
    chk("b1_lat1 mode", int'(mode), 0);
    b1 = 1'b0;
    tick();
    cnt_a = 0;
    for (int t = 0; t < 72; t++) begin
      r = t % 24;
      exp_mode = (r < 16) ? 1 : 2;
      exp_tone = (r < 16) ? ((r / 4) % 2) : 0;
      if (int'(mode) != exp_mode || int'(tone) != exp_tone || burst_done !== 1'b0 ||
          busy !== 1'b1) begin
        cnt_a++;
        $display("burst cycle %0d: mode=%0d tone=%0d done=%0b busy=%0b", t, mode, tone,
                 burst_done, busy);
      end
      tick();
    end
    chk("burst_pattern bad_cycles", cnt_a, 0);
    chk("burst_end mode", int'(mode), 0);
    chk("burst_end done", int'(burst_done), 1);
    chk("burst_end busy", int'(busy), 0);
    tick();
    chk_idle("burst_after");

    // 3. Continuous tone on b2.
    b2 = 1'b1;
    tick(2);
    cnt_a = 0;
    for (int t = 0; t < 18; t++) begin
      if (int'(mode) != 3 || int'(tone) != ((t / 2) % 2) || busy !== 1'b1) cnt_a++;
      tick();
    end
    chk("cont_pattern bad_cycles", cnt_a, 0);
    b2 = 1'b0;
    tick();
    chk("cont_fall_lat1 mode", int'(mode), 3);
    chk("cont_fall_lat1 tone", int'(tone), 1);
    tick();
    chk_idle("cont_fall_lat2");

    // 4. b2 pre-empts the second beep; no resume afterwards.
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    tick(30);
    chk("preempt_pre mode", int'(mode), 1);
    b2 = 1'b1;
    tick();
    chk("preempt_lat1 mode", int'(mode), 1);
    tick();
    chk("preempt_lat2 mode", int'(mode), 3);
    chk("preempt_lat2 tone", int'(tone), 0);
    cnt_a = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (burst_done !== 1'b0 || int'(mode) != 3) cnt_a++;
    end
    chk("preempt_hold bad_cycles", cnt_a, 0);
    b2 = 1'b0;
    tick(2);
    cnt_a = 0;
    for (int t = 0; t < 80; t++) begin
      if (busy !== 1'b0 || burst_done !== 1'b0) cnt_a++;
      tick();
    end
    chk("preempt_no_resume bad_cycles", cnt_a, 0);

    // 5. b1 held high -> back-to-back bursts.
    b1 = 1'b1;
    tick(2);
    chk("b2b_start mode", int'(mode), 1);
    cnt_a = 0; cnt_b = 0; first_done = -1; second_done = -1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (int'(mode) == 0) cnt_b++;
      if (burst_done === 1'b1) begin
        cnt_a++;
        if (first_done < 0) first_done = t;
        else if (second_done < 0) second_done = t;
      end
    end
    chk("b2b done_count", cnt_a, 2);
    chk("b2b first_done", first_done, 72);
    chk("b2b period", second_done - first_done, 73);
    chk("b2b idle_cycles", cnt_b, 2);
    b1 = 1'b0;
    tick(30);
    chk_idle("b2b_release");

    // 6. Reset in the middle of a tone-high beep.
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    tick(5);
    chk("midrst_pre mode", int'(mode), 1);
    chk("midrst_pre tone", int'(tone), 1);
    rst = 1'b1;
    tick();
    chk_idle("midrst");
    rst = 1'b0;
    tick(3);
    chk_idle("midrst_after");

`ifdef BUZZ_MUTE_EN
    mute = 1'b1;
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    tick();
    cnt_a = 0;
    for (int t = 0; t < 72; t++) begin
      r = t % 24;
      exp_mode = (r < 16) ? 1 : 2;
      if (int'(mode) != exp_mode || tone !== 1'b0 || burst_done !== 1'b0) cnt_a++;
      tick();
    end
    chk("mute_pattern bad_cycles", cnt_a, 0);
    chk("mute_end done", int'(burst_done), 1);
    chk("mute_end mode", int'(mode), 0);
    mute = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buzz_pattern_driver.md
Name: buzz_pattern_driver

Overview:
Consumer end of the buzzer alarm interface. It takes the two alarm request levels b1 and b2 produced by the buzzer logic and turns them into an audible square-wave drive for the piezo.
- b1 produces a fixed burst of intermittent beeps.
- b2 produces a continuous higher-pitch tone and has priority over b1.
The block sits between the buzzer decision logic and the board output pin.

Parameters:
TONE_DIV, 4, clock cycles per tone half-period for b1 beeps; must be even and >= 2. The b2 half-period is TONE_DIV/2.
ON_CYC, 16, cycles per beep-on phase; >= 1.
OFF_CYC, 8, cycles per silent gap after each beep; >= 1.
BEEPS, 3, beeps per b1 burst; >= 1.

Ports:
clk  input  1  system clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
b1  input  1  intermittent alarm request (level)
b2  input  1  continuous alarm request (level, priority)
tone  output  1  square-wave drive to the buzzer pin
busy  output  1  high whenever state != IDLE
mode  output  2  current state: 0 IDLE, 1 BEEP_ON, 2 BEEP_OFF, 3 CONT
burst_done  output  1  one-cycle pulse when a b1 burst completes

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: tone=0, busy=0, mode=0, burst_done=0; all counters 0; the b1/b2 sample registers are 0.
- Input stage: b1 and b2 are registered once (b1_q, b2_q). The FSM uses only the registered copies, so latency from an input change to a mode change is 2 clocks. A 1-cycle b1 pulse is captured.
- IDLE:
  - b2_q=1 -> CONT.
  - else b1_q=1 -> BEEP_ON, with beep_cnt=0 and phase_cnt=0.
- BEEP_ON:
  - b2_q=1 -> CONT (preempt; beep_cnt cleared; no burst_done).
  - else phase_cnt==ON_CYC-1 -> BEEP_OFF, phase_cnt=0.
- BEEP_OFF:
  - b2_q=1 -> CONT (preempt, as above).
  - else phase_cnt==OFF_CYC-1:
    - if beep_cnt==BEEPS-1 -> IDLE, pulse burst_done for 1 cycle.
    - else beep_cnt+1 and -> BEEP_ON.
- CONT: b2_q=0 -> IDLE. b1 is ignored while in CONT.
- A burst is committed once started: releasing b1 mid-burst does not shorten it.
- b1 still high at burst end: IDLE for exactly 1 cycle, then a new burst starts.
- Tone generator:
  - On every entry to BEEP_ON or CONT: tone=0, div_cnt=0.
  - In BEEP_ON, tone toggles when div_cnt==TONE_DIV-1; div_cnt then wraps to 0.
  - In CONT, the same rule applies with TONE_DIV/2.
  - In IDLE and BEEP_OFF, tone=0 and div_cnt is held at 0.
- Counter widths are sized with $clog2 of the respective parameter. No counter exceeds its terminal value.
- rst asserted in any state overrides everything: all outputs are at reset values at the next edge.
- Simultaneous b1 and b2 from IDLE -> CONT.

Optional Feature:
Macro BUZZ_MUTE_EN.
- When defined: adds input port mute (1 bit). While mute=1, tone is forced 0 combinationally at the output. The FSM, counters, busy, mode and burst_done run unchanged, so timing is preserved.
- When undefined: no mute port exists, and tone is the raw generator output.

Test Plan:
1. Reset: rst=1 for 2 cycles with b1=b2=1 -> tone=0, busy=0, mode=0, burst_done=0 throughout. After release, mode=3 two cycles later.
2. Single b1 pulse (1 cycle), defaults -> mode=1 two clocks later. tone toggles every 4 cycles (4 toggles per beep), followed by 8 silent cycles; 3 beeps total. burst_done pulses exactly 72 cycles after BEEP_ON entry, then busy=0.
3. b2 held 20 cycles -> mode=3, tone toggles every 2 cycles. b2 falls -> mode=0 and tone=0 two clocks later.
4. b2 asserted during the 2nd beep of a b1 burst -> mode=3 two clocks later, no burst_done. b2 released with b1 low -> IDLE, and no burst resumes.
5. b1 held high for 200 cycles -> back-to-back bursts separated by exactly 1 IDLE cycle. burst_done period is 73 cycles.
6. rst pulsed mid-BEEP_ON with tone=1 -> next edge: tone=0, mode=0, busy=0. With BUZZ_MUTE_EN and mute=1, a b1 burst keeps identical mode/burst_done timing with tone constantly 0.
